// File: rtl/rtc_pkg.sv
// Shared field widths, limits, month codes and the Gregorian leap rule for the
// RTC calendar core and its helpers.
package rtc_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    localparam logic [MON_W-1:0] JAN = 4'd1;
    localparam logic [MON_W-1:0] FEB = 4'd2;
    localparam logic [MON_W-1:0] MAR = 4'd3;
    localparam logic [MON_W-1:0] APR = 4'd4;
    localparam logic [MON_W-1:0] MAY = 4'd5;
    localparam logic [MON_W-1:0] JUN = 4'd6;
    localparam logic [MON_W-1:0] JUL = 4'd7;
    localparam logic [MON_W-1:0] AUG = 4'd8;
    localparam logic [MON_W-1:0] SEP = 4'd9;
    localparam logic [MON_W-1:0] OCT = 4'd10;
    localparam logic [MON_W-1:0] NOV = 4'd11;
    localparam logic [MON_W-1:0] DEC = 4'd12;

    // Gregorian leap test on a zero-extended year (constant-divisor modulo
    // maps to plain logic for widths up to 16 bits). Year 0 counts as leap.
    function automatic logic is_leap(input logic [15:0] year);
        logic div_100;
        logic div_400;
        div_100 = ((year % 16'd100) == 16'd0);
        div_400 = ((year % 16'd400) == 16'd0);
        return (year[1:0] == 2'b00) && (!div_100 || div_400);
    endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// Combinational month length lookup: (month, year) -> number of days.
// Out-of-range month codes report 31; callers range-check the month themselves.
module rtc_days_in_month
    import rtc_pkg::*;
#(
    parameter int YEAR_W = 12
) (
    input  logic [MON_W-1:0]  i_month,
    input  logic [YEAR_W-1:0] i_year,
    output logic [DAY_W-1:0]  o_days
);

    logic [15:0] w_year16;
    logic        w_leap;

    assign w_year16 = 16'(i_year);
    assign w_leap   = is_leap(w_year16);

    // Month length table with the February leap adjustment.
    always_comb begin
        o_days = 5'd31;
        case (i_month)
            APR, JUN, SEP, NOV: o_days = 5'd30;
            FEB:                o_days = w_leap ? 5'd29 : 5'd28;
            default:            o_days = 5'd31;
        endcase
    end

endmodule

// File: rtl/rtc_calendar_core.sv
// Time-of-day plus Gregorian date keeper with clock prescaler, run/stop,
// validated synchronous load and one-cycle rollover strobes.
// Optional alarm comparator is compiled in when RTC_ALARM_EN is defined.
module rtc_calendar_core
    import rtc_pkg::*;
#(
    parameter int TICK_DIV   = 1,
    parameter int YEAR_W     = 12,
    parameter int RESET_YEAR = 2000
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic              run,
    input  logic              load,
    input  logic [5:0]        ld_sec,
    input  logic [5:0]        ld_min,
    input  logic [4:0]        ld_hour,
    input  logic [4:0]        ld_day,
    input  logic [3:0]        ld_month,
    input  logic [YEAR_W-1:0] ld_year,
    output logic [5:0]        sec,
    output logic [5:0]        min,
    output logic [4:0]        hour,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              sec_tick,
    output logic              day_roll,
    output logic              load_err
`ifdef RTC_ALARM_EN
    ,
    input  logic              alarm_arm,
    input  logic [4:0]        alarm_hour,
    input  logic [5:0]        alarm_min,
    output logic              alarm_hit
`endif
);

    localparam int                DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [YEAR_W-1:0] RST_YEAR = YEAR_W'(RESET_YEAR);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [SEC_W-1:0]  r_sec;
    logic [MIN_W-1:0]  r_min;
    logic [HOUR_W-1:0] r_hour;
    logic [DAY_W-1:0]  r_day;
    logic [MON_W-1:0]  r_month;
    logic [YEAR_W-1:0] r_year;
    logic              r_sec_tick;
    logic              r_day_roll;
    logic              r_load_err;

    logic              w_tick;
    logic              w_ld_valid;
    logic [DAY_W-1:0]  w_dim;
    logic [DAY_W-1:0]  w_ld_dim;
    logic              w_sec_wrap;
    logic              w_min_wrap;
    logic              w_hour_wrap;
    logic              w_day_wrap;
    logic              w_mon_wrap;
    logic [SEC_W-1:0]  w_sec_nx;
    logic [MIN_W-1:0]  w_min_nx;
    logic [HOUR_W-1:0] w_hour_nx;
    logic [DAY_W-1:0]  w_day_nx;
    logic [MON_W-1:0]  w_month_nx;
    logic [YEAR_W-1:0] w_year_nx;

    // Length of the month currently shown, for the day carry.
    rtc_days_in_month #(.YEAR_W(YEAR_W)) u_dim_cur (
        .i_month (r_month),
        .i_year  (r_year),
        .o_days  (w_dim)
    );

    // Length of the month being loaded, for load validation.
    rtc_days_in_month #(.YEAR_W(YEAR_W)) u_dim_ld (
        .i_month (ld_month),
        .i_year  (ld_year),
        .o_days  (w_ld_dim)
    );

    assign w_tick = run && (r_div_cnt == DIV_LAST);

    // Range check of all load fields in the load cycle.
    always_comb begin
        w_ld_valid = (ld_sec <= SEC_MAX) && (ld_min <= MIN_MAX) &&
                     (ld_hour <= HOUR_MAX) &&
                     (ld_month >= JAN) && (ld_month <= DEC) &&
                     (ld_day >= 5'd1) && (ld_day <= w_ld_dim);
    end

    // One-second advance chain; every field's next value is computed in parallel.
    always_comb begin
        w_sec_wrap  = (r_sec == SEC_MAX);
        w_min_wrap  = w_sec_wrap && (r_min == MIN_MAX);
        w_hour_wrap = w_min_wrap && (r_hour == HOUR_MAX);
        w_day_wrap  = w_hour_wrap && (r_day == w_dim);
        w_mon_wrap  = w_day_wrap && (r_month == DEC);

        w_sec_nx   = w_sec_wrap ? '0 : r_sec + 1'b1;
        w_min_nx   = !w_sec_wrap ? r_min : (w_min_wrap ? '0 : r_min + 1'b1);
        w_hour_nx  = !w_min_wrap ? r_hour : (w_hour_wrap ? '0 : r_hour + 1'b1);
        w_day_nx   = !w_hour_wrap ? r_day : (w_day_wrap ? 5'd1 : r_day + 1'b1);
        w_month_nx = !w_day_wrap ? r_month : (w_mon_wrap ? JAN : r_month + 1'b1);
        // Natural overflow of the YEAR_W-bit adder gives the max->0 wrap.
        w_year_nx  = w_mon_wrap ? r_year + 1'b1 : r_year;
    end

    // Prescaler, calendar registers and strobes; reset beats valid load beats tick.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_div_cnt  <= '0;
            r_sec      <= '0;
            r_min      <= '0;
            r_hour     <= '0;
            r_day      <= 5'd1;
            r_month    <= JAN;
            r_year     <= RST_YEAR;
            r_sec_tick <= 1'b0;
            r_day_roll <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_day_roll <= 1'b0;
            r_load_err <= 1'b0;
            if (load && w_ld_valid) begin
                // A coincident tick is dropped so the loaded value appears as-is.
                r_div_cnt <= '0;
                r_sec     <= ld_sec;
                r_min     <= ld_min;
                r_hour    <= ld_hour;
                r_day     <= ld_day;
                r_month   <= ld_month;
                r_year    <= ld_year;
            end else begin
                r_load_err <= load;
                if (w_tick) begin
                    r_div_cnt  <= '0;
                    r_sec      <= w_sec_nx;
                    r_min      <= w_min_nx;
                    r_hour     <= w_hour_nx;
                    r_day      <= w_day_nx;
                    r_month    <= w_month_nx;
                    r_year     <= w_year_nx;
                    r_sec_tick <= 1'b1;
                    r_day_roll <= w_hour_wrap;
                end else if (run) begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end
        end
    end

`ifdef RTC_ALARM_EN
    logic r_alarm_hit;

    // Alarm fires only on a tick-driven advance landing on hh:mm:00.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_alarm_hit <= 1'b0;
        end else begin
            r_alarm_hit <= !(load && w_ld_valid) && w_tick && alarm_arm &&
                           (w_sec_nx == '0) && (w_hour_nx == alarm_hour) &&
                           (w_min_nx == alarm_min);
        end
    end

    assign alarm_hit = r_alarm_hit;
`endif

    assign sec      = r_sec;
    assign min      = r_min;
    assign hour     = r_hour;
    assign day      = r_day;
    assign month    = r_month;
    assign year     = r_year;
    assign sec_tick = r_sec_tick;
    assign day_roll = r_day_roll;
    assign load_err = r_load_err;

endmodule
